// File: rtl/booth_mult_seq_if.sv
// Start/operand/result handshake bundle for booth_mult_seq.
// ctrl_UNSIGNED exists only when MULT_UNSIGNED_EN is defined.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
`ifdef MULT_UNSIGNED_EN
  logic             ctrl_UNSIGNED;
`endif
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;

`ifdef MULT_UNSIGNED_EN
  modport master (
    output ctrl_MULT, data_operandA, data_operandB, ctrl_UNSIGNED,
    input  data_result, data_exception, data_resultRDY, data_busy
  );
  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, ctrl_UNSIGNED,
    output data_result, data_exception, data_resultRDY, data_busy
  );
`else
  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, data_busy
  );
  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, data_busy
  );
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: two multiplier bits retired per clock.
// Define MULT_UNSIGNED_EN to add ctrl_UNSIGNED (zero-extension plus one extra step).
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             reset_n,
  booth_mult_seq_if.slave bus
);

  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(WIDTH / 2 - 1);
`ifdef MULT_UNSIGNED_EN
  localparam logic [CNT_W-1:0] LAST_U = CNT_W'(WIDTH / 2);
`endif

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end
  if ((2 ** CNT_W) <= (WIDTH / 2 + 1)) begin : g_bad_cnt
    $error("booth_mult_seq: CNT_W too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic signed [EW-1:0]  mcand;
  logic signed [AW-1:0]  acc;
  logic        [EW-1:0]  mplr;
  logic                  saved_bit;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] cnt_last;
  logic                  fin;
  logic                  uns;
  logic                  uns_in;
  logic                  step;
  logic                  capture;
  logic                  busy;
  logic                  rdy;
  logic signed [AW-1:0]  sum;
  logic [2*WIDTH-1:0]    prod;
  logic [WIDTH-1:0]      res;
  logic                  exc;

  // Booth digit for triplet {b[2i+1], b[2i], b[2i-1]} applied to the multiplicand.
  function automatic logic signed [AW-1:0] booth_addend(input logic [2:0] trip,
                                                        input logic [EW-1:0] m);
    logic signed [AW-1:0] m1;
    logic signed [AW-1:0] m2;
    m1 = {m[EW-1], m};
    m2 = {m, 1'b0};
    case (trip)
      3'b001, 3'b010: booth_addend = m1;
      3'b011:         booth_addend = m2;
      3'b100:         booth_addend = -m2;
      3'b101, 3'b110: booth_addend = -m1;
      default:        booth_addend = '0;
    endcase
  endfunction

  function automatic logic overflow(input logic [2*WIDTH-1:0] p, input logic u);
    logic hi_any;
    logic hi_all;
    hi_any = |p[2*WIDTH-1:WIDTH-1];
    hi_all = &p[2*WIDTH-1:WIDTH-1];
    if (u) overflow = |p[2*WIDTH-1:WIDTH];
    else   overflow = hi_any & ~hi_all;
  endfunction

`ifdef MULT_UNSIGNED_EN
  assign uns_in   = bus.ctrl_UNSIGNED;
  assign cnt_last = uns ? LAST_U : LAST_S;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           uns <= 1'b0;
    else if (bus.ctrl_MULT) uns <= bus.ctrl_UNSIGNED;
  end
`else
  assign uns_in   = 1'b0;
  assign uns      = 1'b0;
  assign cnt_last = LAST_S;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    capture   = 1'b0;
    busy      = 1'b0;
    rdy       = 1'b0;
    case (state)
      IDLE: ;
      RUN: begin
        busy = 1'b1;
        if (fin) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        rdy       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A start wins in every state, aborting whatever was in flight.
    if (bus.ctrl_MULT) begin
      state_nxt = RUN;
      step      = 1'b0;
      capture   = 1'b0;
    end
  end

  assign sum = acc + booth_addend({mplr[1:0], saved_bit}, mcand);

  // Unsigned runs one extra step, so the product sits two bits further down.
  always_comb begin
    if (uns) prod = {acc[WIDTH-3:0], mplr};
    else     prod = {acc[WIDTH-1:0], mplr[EW-1:2]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
      saved_bit <= 1'b0;
      cnt       <= '0;
      fin       <= 1'b0;
      res       <= '0;
      exc       <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      mcand     <= {{2{bus.data_operandA[WIDTH-1] & ~uns_in}}, bus.data_operandA};
      mplr      <= {{2{bus.data_operandB[WIDTH-1] & ~uns_in}}, bus.data_operandB};
      acc       <= '0;
      saved_bit <= 1'b0;
      cnt       <= '0;
      fin       <= 1'b0;
      res       <= '0;
      exc       <= 1'b0;
    end else if (step) begin
      acc       <= {{2{sum[AW-1]}}, sum[AW-1:2]};
      mplr      <= {sum[1:0], mplr[EW-1:2]};
      saved_bit <= mplr[1];
      if (cnt != cnt_last) cnt <= cnt + CNT_W'(1);
      fin       <= (cnt == cnt_last);
    end else if (capture) begin
      res       <= prod[WIDTH-1:0];
      exc       <= overflow(prod, uns);
    end
  end

  assign bus.data_result    = res;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;
  assign bus.data_busy      = busy;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH 32 and WIDTH 8: a plain-arithmetic
// product/latency model compared every cycle, plus hand-computed literal vectors.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(32)) b32 ();
  booth_mult_seq_if #(.WIDTH(8))  b8 ();

  booth_mult_seq #(.WIDTH(32), .CNT_W(5)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32.slave));
  booth_mult_seq #(.WIDTH(8),  .CNT_W(3)) dut8  (.clk(clk), .reset_n(reset_n), .bus(b8.slave));

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Exact product from integer arithmetic; returns {exception, low 32 bits of result}.
  function automatic logic [32:0] model_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit u);
    longint msk, sa, sb, p, lo, slo;
    logic   e;
    msk = (longint'(1) << w) - 1;
    sa  = longint'(a) & msk;
    sb  = longint'(b) & msk;
    if (!u && sa[w-1]) sa = sa - (longint'(1) << w);
    if (!u && sb[w-1]) sb = sb - (longint'(1) << w);
    p  = sa * sb;
    lo = p & msk;
    if (u) begin
      e = (((p >> w) & msk) != 0);
    end else begin
      slo = lo;
      if (lo[w-1]) slo = slo - (longint'(1) << w);
      e = (p != slo);
    end
    return {e, lo[31:0]};
  endfunction

  logic [31:0] m_res[2];
  logic [31:0] pend_res[2];
  bit          m_exc[2], pend_exc[2], m_rdy[2], m_busy[2];
  int          m_rem[2];
  logic        u32, u8;

`ifdef MULT_UNSIGNED_EN
  assign u32 = b32.ctrl_UNSIGNED;
  assign u8  = b8.ctrl_UNSIGNED;
`else
  assign u32 = 1'b0;
  assign u8  = 1'b0;
`endif

  task automatic model_clear(input int k);
    m_res[k] = '0; m_exc[k] = 1'b0; m_rdy[k] = 1'b0; m_busy[k] = 1'b0; m_rem[k] = 0;
  endtask

  // m_rem = edges remaining until the result strobe.
  task automatic model_step(input int k, input bit start, input logic [31:0] a,
                            input logic [31:0] b, input bit u, input int w);
    logic [32:0] r;
    if (start) begin
      r = model_mul(w, a, b, u);
      pend_res[k] = r[31:0];
      pend_exc[k] = r[32];
      m_rem[k]  = w / 2 + (u ? 1 : 0) + 1;
      m_rdy[k]  = 1'b0;
      m_busy[k] = 1'b1;
      m_res[k]  = '0;
      m_exc[k]  = 1'b0;
    end else if (m_rem[k] > 1) begin
      m_rem[k]--;
    end else if (m_rem[k] == 1) begin
      m_rem[k] = 0;
      m_rdy[k] = 1'b1;
      m_res[k] = pend_res[k];
      m_exc[k] = pend_exc[k];
    end else if (m_rdy[k]) begin
      m_rdy[k]  = 1'b0;
      m_busy[k] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_clear(0);
    else model_step(0, b32.ctrl_MULT, b32.data_operandA, b32.data_operandB, u32, 32);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_clear(1);
    else model_step(1, b8.ctrl_MULT, {24'd0, b8.data_operandA}, {24'd0, b8.data_operandB}, u8, 8);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_res32",  b32.data_result,    m_res[0]);
      check("cyc_exc32",  b32.data_exception, m_exc[0]);
      check("cyc_rdy32",  b32.data_resultRDY, m_rdy[0]);
      check("cyc_busy32", b32.data_busy,      m_busy[0]);
      check("cyc_res8",   b8.data_result,     m_res[1][7:0]);
      check("cyc_exc8",   b8.data_exception,  m_exc[1]);
      check("cyc_rdy8",   b8.data_resultRDY,  m_rdy[1]);
      check("cyc_busy8",  b8.data_busy,       m_busy[1]);
    end
  end

  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit u);
    @(negedge clk);
    if (k == 0) begin
      b32.ctrl_MULT = 1'b1; b32.data_operandA = a; b32.data_operandB = b;
`ifdef MULT_UNSIGNED_EN
      b32.ctrl_UNSIGNED = u;
`endif
    end else begin
      b8.ctrl_MULT = 1'b1; b8.data_operandA = a[7:0]; b8.data_operandB = b[7:0];
`ifdef MULT_UNSIGNED_EN
      b8.ctrl_UNSIGNED = u;
`endif
    end
    @(negedge clk);
    if (k == 0) begin
      b32.ctrl_MULT = 1'b0; b32.data_operandA = $urandom(); b32.data_operandB = $urandom();
    end else begin
      b8.ctrl_MULT = 1'b0; b8.data_operandA = 8'($urandom()); b8.data_operandB = 8'($urandom());
    end
  endtask

  // Counts rising edges after the start edge until the strobe; -1 on timeout.
  task automatic wait_rdy(input int k, input int max_edges, output int edges);
    edges = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk); #1;
      if (((k == 0) ? b32.data_resultRDY : b8.data_resultRDY) === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  vec_t vt[8];
  int   lat;
  int   rdy_seen;

  initial begin
    vt[0] = '{32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vt[1] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vt[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[3] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vt[4] = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};
    vt[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
    vt[6] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vt[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};

    b32.ctrl_MULT = 1'b0; b32.data_operandA = '0; b32.data_operandB = '0;
    b8.ctrl_MULT  = 1'b0; b8.data_operandA  = '0; b8.data_operandB  = '0;
`ifdef MULT_UNSIGNED_EN
    b32.ctrl_UNSIGNED = 1'b0;
    b8.ctrl_UNSIGNED  = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy32", b32.data_busy, 1'b0);
    check("rst_rdy32",  b32.data_resultRDY, 1'b0);
    check("rst_res32",  b32.data_result, 32'd0);
    check("rst_exc32",  b32.data_exception, 1'b0);
    check("rst_busy8",  b8.data_busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    foreach (vt[i]) begin
      start_op(0, vt[i].a, vt[i].b, 1'b0);
      wait_rdy(0, 40, lat);
      check($sformatf("lat_vec%0d", i), lat, 17);
      check($sformatf("res_vec%0d", i), b32.data_result, vt[i].res);
      check($sformatf("exc_vec%0d", i), b32.data_exception, vt[i].exc);
      @(posedge clk); #1;
      check($sformatf("rdy_fall_vec%0d", i), b32.data_resultRDY, 1'b0);
      check($sformatf("hold_vec%0d", i), b32.data_result, vt[i].res);
    end

    // Restart: 5 x 6 aborted by 9 x 9 sampled eight edges later.
    start_op(0, 32'd5, 32'd6, 1'b0);
    repeat (6) @(negedge clk);
    start_op(0, 32'd9, 32'd9, 1'b0);
    wait_rdy(0, 40, lat);
    check("restart_lat", lat, 17);
    check("restart_res", b32.data_result, 32'd81);

    // Start held for three edges: only the last operands count.
    @(negedge clk);
    b32.ctrl_MULT = 1'b1; b32.data_operandA = 32'd11;  b32.data_operandB = 32'd13;
    @(negedge clk);
    b32.data_operandA = -32'sd1234; b32.data_operandB = 32'd5678;
    @(negedge clk);
    b32.data_operandA = -32'sd100000; b32.data_operandB = -32'sd3;
    @(negedge clk);
    b32.ctrl_MULT = 1'b0;
    wait_rdy(0, 40, lat);
    check("hold_lat", lat, 17);
    check("hold_res", b32.data_result, 32'h0004_93E0);

`ifdef MULT_UNSIGNED_EN
    start_op(0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_rdy(0, 40, lat);
    check("uns_lat", lat, 18);
    check("uns_res", b32.data_result, 32'hFFFF_FFFE);
    check("uns_exc", b32.data_exception, 1'b1);
    start_op(0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_rdy(0, 40, lat);
    check("sgn_lat", lat, 17);
    check("sgn_res", b32.data_result, 32'hFFFF_FFFE);
    check("sgn_exc", b32.data_exception, 1'b0);
`endif

    // WIDTH 8: -128 x -1 overflows; then a back-to-back start in DONE.
    start_op(1, 32'h80, 32'hFF, 1'b0);
    wait_rdy(1, 20, lat);
    check("w8_lat", lat, 5);
    check("w8_res", b8.data_result, 8'h80);
    check("w8_exc", b8.data_exception, 1'b1);
    @(negedge clk);
    b8.ctrl_MULT = 1'b1; b8.data_operandA = 8'd3; b8.data_operandB = 8'hFB;
    @(posedge clk); #1;
    check("b2b_rdy_fall", b8.data_resultRDY, 1'b0);
    check("b2b_busy",     b8.data_busy, 1'b1);
    check("b2b_res_clr",  b8.data_result, 8'h00);
    @(negedge clk);
    b8.ctrl_MULT = 1'b0;
    wait_rdy(1, 20, lat);
    check("b2b_lat", lat, 5);
    check("b2b_res", b8.data_result, 8'hF1);
    check("b2b_exc", b8.data_exception, 1'b0);

    // Reset coinciding with a start keeps the block idle.
    @(negedge clk);
    cmp_en = 1'b0;
    reset_n = 1'b0;
    b32.ctrl_MULT = 1'b1; b32.data_operandA = 32'd3; b32.data_operandB = 32'd4;
    @(posedge clk); #1;
    check("rst_start_busy", b32.data_busy, 1'b0);
    @(negedge clk);
    b32.ctrl_MULT = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset dropped at edge 10 of a run.
    start_op(0, 32'd5, 32'd6, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    cmp_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", b32.data_busy, 1'b0);
    check("midrst_rdy",  b32.data_resultRDY, 1'b0);
    check("midrst_res",  b32.data_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (b32.data_resultRDY === 1'b1) rdy_seen++;
    end
    check("midrst_no_rdy", rdy_seen, 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-4 Booth multiplier: a control FSM, iteration counter and shift/add datapath in one block. It replaces the fixed 32-bit multiplier controller in the ALU's multi-cycle path. It supports any even operand width, optional unsigned operation, and a one-cycle result-ready strobe with an overflow flag. It retires two multiplier bits per clock and sits beside the divider under the same `ctrl_MULT`/`data_resultRDY` handshake.

## Interface
- `WIDTH`, default 32: operand and result width. Must be even and ≥ 4.
- `CNT_W`, default 5: iteration counter width. Must satisfy 2^CNT_W > WIDTH/2 + 1.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ctrl_MULT`  in  1: start pulse; operands are sampled on the same edge.
- `data_operandA`  in  WIDTH: multiplicand.
- `data_operandB`  in  WIDTH: multiplier; Booth-recoded.
- `ctrl_UNSIGNED`  in  1: unsigned mode. Present only with `MULT_UNSIGNED_EN`.
- `data_result`  out  WIDTH: low WIDTH bits of the product.
- `data_exception`  out  1: product does not fit in WIDTH bits.
- `data_resultRDY`  out  1: one-cycle strobe; result and exception are valid.
- `data_busy`  out  1: high while an operation is in progress.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: all outputs 0; counter 0; product register 0.
- Start: `ctrl_MULT` = 1 on an edge in any state loads the operands, clears the counter and product, and enters RUN.
  - This includes RUN and DONE, so an in-flight operation is aborted and restarted.
- Operand extension: A and B are extended by 2 bits to WIDTH+2.
  - Signed mode: sign-extend.
  - Unsigned mode: zero-extend.
- Iteration count N:
  - Signed mode: N = WIDTH/2.
  - Unsigned mode: N = WIDTH/2 + 1. The extra step absorbs the zero-extended MSB.
- Each RUN cycle examines the triplet {B[2i+1], B[2i], B[2i-1]}, with B[-1] = 0 held in a saved-bit flop.
- Recoding action on the partial product:
  - 000 or 111: +0.
  - 001 or 010: +A.
  - 011: +2A.
  - 100: −2A.
  - 101 or 110: −A.
- After each add, the partial product is shifted arithmetic-right by 2. The adder is WIDTH+3 bits wide.
- When the counter reaches N−1, the next edge moves the FSM to DONE and registers the results:
  - `data_result` = product[WIDTH−1:0].
  - Signed exception: product[2·WIDTH−1:WIDTH−1] is not all-equal.
  - Unsigned exception: product[2·WIDTH−1:WIDTH] ≠ 0.
- DONE lasts one cycle with `data_resultRDY` = 1, then returns to IDLE.
- `data_result` and `data_exception` hold their values until the next accepted `ctrl_MULT`. They clear to 0 on that edge.
- `data_busy` = 1 in RUN and DONE.
- Counter never wraps: it saturates at N−1 and is cleared only by a start or by reset.

## Timing
- Latency: `ctrl_MULT` sampled at edge E0 puts `data_resultRDY` high for exactly the one cycle following edge E(N+1).
  - Default signed: N+1 = 17 edges.
  - Default unsigned: N+1 = 18 edges.
- Back-to-back: `ctrl_MULT` asserted during the DONE cycle is accepted. The new RUN begins with no idle gap, and `data_resultRDY` falls on that edge.
- `ctrl_MULT` held high for several cycles restarts on every edge. The operation completes only N+1 edges after the last high sample.
- Simultaneous reset and `ctrl_MULT`: reset wins, and the FSM stays in IDLE.
- Reset mid-RUN: all outputs go to 0 immediately (asynchronously). No `data_resultRDY` is issued.
- Operands need to be stable only at the sampling edge; they are not re-read afterwards.

## Configuration
- Macro: `MULT_UNSIGNED_EN`.
- Defined:
  - The `ctrl_UNSIGNED` port exists.
  - It is sampled with `ctrl_MULT` and selects zero-extension, N = WIDTH/2 + 1, and unsigned overflow detection.
- Undefined:
  - The port is absent.
  - The block is signed-only with a fixed N = WIDTH/2. The extra-iteration logic is removed.

## Test plan
- Signed, WIDTH = 32: A = 7, B = −3, pulse `ctrl_MULT` → after 17 edges, `data_result` = 0xFFFFFFEB, exception = 0, RDY high for exactly 1 cycle.
- Overflow: A = 0x00010000, B = 0x00010000 → `data_result` = 0x00000000, `data_exception` = 1.
- Restart: start 5 × 6; re-pulse at edge 8 with 9 × 9 → a single RDY 17 edges after the re-pulse, with `data_result` = 81.
- Reset mid-RUN: drop `reset_n` at edge 10 → `data_busy`, RDY and `data_result` read 0 immediately; no RDY follows.
- Unsigned (`MULT_UNSIGNED_EN`): A = 0xFFFFFFFF, B = 2, `ctrl_UNSIGNED` = 1 → after 18 edges, result = 0xFFFFFFFE, exception = 1. The same operands signed give 0xFFFFFFFE with exception = 0.
- WIDTH = 8, CNT_W = 3: A = 0x80, B = 0xFF → result 0x80, exception 1 (+128 does not fit), after 5 edges. Back-to-back start in DONE, with no gap.
